// File: rtl/npu_pkg.sv
// Shared types and default latencies for the NPU convolution scheduler.
package npu_pkg;

    localparam int unsigned ACC_LATENCY_DEF  = 12;
    localparam int unsigned POST_LATENCY_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Bubbles carry an all-zero tag so they can never restart or finish a pixel.
    function automatic tag_t make_tag(input logic beat, input logic first, input logic last);
        tag_t t;
        t.valid = beat;
        t.first = beat & first;
        t.last  = beat & last;
        return t;
    endfunction

endpackage

// File: rtl/npu_tag_pipe.sv
// Shift-register delay line for beat tags with synchronous clear.
module npu_tag_pipe
    import npu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAP   = 12
) (
    input  logic clk,
    input  logic clr,
    input  tag_t din,
    output tag_t tap,
    output tag_t tail,
    output logic any_valid
);

    tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (clr) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], din};
        end
    end

    // stage[k] presents a tag k+1 cycles after it was issued.
    assign tap  = stage[TAP-1];
    assign tail = stage[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/npu_conv_sched.sv
// Convolution job scheduler: sequences parameter load, beat issue and pipeline drain for the MAC core.
// Optional perf counters are enabled by defining NPU_SCHED_PERF_EN.
module npu_conv_sched
    import npu_pkg::*;
#(
    parameter int unsigned MAC_OUT_NUM  = 18,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned ACC_LATENCY  = ACC_LATENCY_DEF,
    parameter int unsigned POST_LATENCY = POST_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [CNT_WIDTH-1:0]   cfg_acc_len,
    input  logic [CNT_WIDTH-1:0]   cfg_out_num,
    input  logic [3:0]             cfg_scale,
    output logic                   param_req,
    input  logic                   param_vld,
    output logic                   data_req,
    input  logic                   data_vld,
    output logic                   mac_data_valid,
    output logic                   mac_data_gate,
    output logic                   mac_weight_valid,
    output logic                   mac_bias_valid,
    output logic [3:0]             mac_scale,
    output logic [MAC_OUT_NUM-1:0] adder_rst,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
`ifdef NPU_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_busy_cyc,
    output logic [31:0]            perf_stall_cyc
`endif
);

    localparam int unsigned PIPE_DEPTH = ACC_LATENCY + 1 + POST_LATENCY;

    sched_state_t         state;
    logic [CNT_WIDTH-1:0] acc_len_q;
    logic [CNT_WIDTH-1:0] out_num_q;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [3:0]           scale_q;
    logic                 param_req_q;
    logic                 data_req_q;
    logic                 wb_vld_q;
    logic                 done_q;

    logic beat;
    logic beat_last;
    logic pix_last;
    tag_t tag_in;
    tag_t tag_tap;
    tag_t tag_tail;
    logic pipe_busy;
    logic unused_tag_bits;

    assign beat      = data_req_q & data_vld;
    assign beat_last = (beat_cnt == acc_len_q - CNT_WIDTH'(1));
    assign pix_last  = (pix_cnt == out_num_q - CNT_WIDTH'(1));
    assign tag_in    = make_tag(beat, beat_cnt == '0, beat_last);

    // Job sequencing, counters and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc_len_q   <= '0;
            out_num_q   <= '0;
            beat_cnt    <= '0;
            pix_cnt     <= '0;
            scale_q     <= '0;
            param_req_q <= 1'b0;
            data_req_q  <= 1'b0;
            wb_vld_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wb_vld_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        acc_len_q   <= (cfg_acc_len == '0) ? CNT_WIDTH'(1) : cfg_acc_len;
                        out_num_q   <= cfg_out_num;
                        scale_q     <= cfg_scale;
                        beat_cnt    <= '0;
                        pix_cnt     <= '0;
                        param_req_q <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (param_vld) begin
                        param_req_q <= 1'b0;
                        wb_vld_q    <= 1'b1;
                        if (out_num_q == '0) begin
                            done_q <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            data_req_q <= 1'b1;
                            state      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            pix_cnt  <= pix_cnt + CNT_WIDTH'(1);
                            if (pix_last) begin
                                data_req_q <= 1'b0;
                                state      <= ST_DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        done_q <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    npu_tag_pipe #(
        .DEPTH (PIPE_DEPTH),
        .TAP   (ACC_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (rst),
        .din       (tag_in),
        .tap       (tag_tap),
        .tail      (tag_tail),
        .any_valid (pipe_busy)
    );

    assign unused_tag_bits = tag_tap.last ^ tag_tail.first;

    assign param_req        = param_req_q;
    assign data_req         = data_req_q;
    assign mac_data_valid   = beat;
    assign mac_data_gate    = ~beat;
    assign mac_weight_valid = wb_vld_q;
    assign mac_bias_valid   = wb_vld_q;
    assign mac_scale        = scale_q;
    assign adder_rst        = {MAC_OUT_NUM{tag_tap.valid & tag_tap.first}};
    assign out_valid        = tag_tail.valid & tag_tail.last;
    assign busy             = (state != ST_IDLE);
    assign done             = done_q;

`ifdef NPU_SCHED_PERF_EN
    // Counters clear on an accepted start and hold once the job returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (state == ST_IDLE) begin
            if (cfg_start) begin
                perf_busy_cyc  <= '0;
                perf_stall_cyc <= '0;
            end
        end else begin
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (state == ST_RUN && !data_vld) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npu_conv_sched.sv
// Scoreboard bench for npu_conv_sched: driver predicts event times, negedge monitor checks them.
module tb_npu_conv_sched;

    localparam int unsigned CW      = 16;
    localparam int unsigned MON     = 18;
    localparam int          ACC_LAT = 12;
    localparam int          LAT_OUT = 12 + 1 + 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_start = 1'b0;
    logic [CW-1:0]  cfg_acc_len = '0;
    logic [CW-1:0]  cfg_out_num = '0;
    logic [3:0]     cfg_scale = '0;
    logic           param_vld = 1'b0;
    logic           data_vld = 1'b0;
    logic           param_req, data_req, mac_data_valid, mac_data_gate;
    logic           mac_weight_valid, mac_bias_valid, out_valid, busy, done;
    logic [3:0]     mac_scale;
    logic [MON-1:0] adder_rst;
`ifdef NPU_SCHED_PERF_EN
    logic [31:0]    perf_busy_cyc, perf_stall_cyc;
`endif

    npu_conv_sched dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_acc_len      (cfg_acc_len),
        .cfg_out_num      (cfg_out_num),
        .cfg_scale        (cfg_scale),
        .param_req        (param_req),
        .param_vld        (param_vld),
        .data_req         (data_req),
        .data_vld         (data_vld),
        .mac_data_valid   (mac_data_valid),
        .mac_data_gate    (mac_data_gate),
        .mac_weight_valid (mac_weight_valid),
        .mac_bias_valid   (mac_bias_valid),
        .mac_scale        (mac_scale),
        .adder_rst        (adder_rst),
        .out_valid        (out_valid),
        .busy             (busy),
        .done             (done)
`ifdef NPU_SCHED_PERF_EN
        ,
        .perf_busy_cyc    (perf_busy_cyc),
        .perf_stall_cyc   (perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int fail = 0;
    int rst_q[$];
    int out_q[$];
    bit mon_en = 1'b0;
    bit exp_req = 1'b0, exp_beat = 1'b0, exp_preq = 1'b0, exp_wb = 1'b0, exp_busy = 1'b0;
    logic [3:0] exp_scale = '0;
    int done_cnt = 0, done_cyc = 0, out_cnt = 0, rst_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle handshake expectations and timestamped event queues.
    always @(negedge clk) begin
        if (mon_en) begin
            int exp_t;
            check("data_req", data_req, exp_req);
            check("mac_data_valid", mac_data_valid, exp_beat);
            check("mac_data_gate", mac_data_gate, !exp_beat);
            check("param_req", param_req, exp_preq);
            check("mac_bias_valid", mac_bias_valid, exp_wb);
            check("mac_weight_valid", mac_weight_valid, exp_wb);
            check("busy", busy, exp_busy);
            check("mac_scale", mac_scale, exp_scale);
            if (adder_rst != '0) begin
                rst_cnt++;
                check("adder_rst_bits", adder_rst, {MON{1'b1}});
                exp_t = (rst_q.size() > 0) ? rst_q[0] : -1;
                check("adder_rst_cycle", cyc, exp_t);
                if (rst_q.size() > 0 && rst_q[0] <= cyc) void'(rst_q.pop_front());
            end else if (rst_q.size() > 0 && rst_q[0] <= cyc) begin
                check("adder_rst_cycle", -1, rst_q[0]);
                void'(rst_q.pop_front());
            end
            if (out_valid) begin
                out_cnt++;
                exp_t = (out_q.size() > 0) ? out_q[0] : -1;
                check("out_valid_cycle", cyc, exp_t);
                if (out_q.size() > 0 && out_q[0] <= cyc) void'(out_q.pop_front());
            end else if (out_q.size() > 0 && out_q[0] <= cyc) begin
                check("out_valid_cycle", -1, out_q[0]);
                void'(out_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_drain", out_q.size() + rst_q.size(), 0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            data_vld = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mon_en = 1'b0; cfg_start = 1'b0; param_vld = 1'b0;
        exp_req = 0; exp_beat = 0; exp_wb = 0; exp_preq = 0; exp_busy = 0; exp_scale = '0;
        rst_q.delete(); out_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1;
        out_cnt = 0; rst_cnt = 0; done_cnt = 0;
    endtask

    // One job; the reference model is beat index arithmetic over acc_len and out_num.
    task automatic run_job(input int L, input int N, input int sc, input int bub_pct, input int pdelay,
                           input int stall_after, input int stall_len, input bit mid_start, input int rst_after);
        int leff = (L == 0) ? 1 : L;
        int total = leff * N;
        int beats = 0, bubbles = 0, stall_used = 0, run_cyc = 0, wait_c = 0, s;
        bit v;
        out_cnt = 0; rst_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_acc_len = CW'(L); cfg_out_num = CW'(N); cfg_scale = 4'(sc);
        data_vld = 1'($urandom);
        s = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_acc_len = CW'($urandom); cfg_out_num = CW'($urandom); cfg_scale = 4'($urandom);
        exp_busy = 1; exp_scale = 4'(sc); exp_preq = 1;
        for (int i = 0; i < pdelay; i++) begin
            data_vld = 1'($urandom);
            @(posedge clk); #1;
        end
        param_vld = 1'b1;
        @(posedge clk); #1;
        param_vld = 1'b0; exp_preq = 0; exp_wb = 1;
        while (beats < total) begin
            exp_req = 1;
            if (rst_after >= 0 && beats == rst_after) begin
                do_reset();
                idle(25);
                check("post_reset_out_valid", out_cnt, 0);
                check("post_reset_adder_rst", rst_cnt, 0);
                check("post_reset_done", done_cnt, 0);
                return;
            end
            if (mid_start && run_cyc == 3) begin
                cfg_start = 1'b1;
                cfg_acc_len = CW'($urandom_range(9, 1)); cfg_out_num = CW'($urandom_range(9, 1));
                cfg_scale = 4'($urandom);
            end else begin
                cfg_start = 1'b0;
            end
            if (stall_after >= 0 && beats == stall_after && stall_used < stall_len) begin
                v = 1'b0;
                stall_used++;
            end else begin
                v = ($urandom_range(99) >= bub_pct);
            end
            data_vld = v; exp_beat = v;
            if (v) begin
                if (beats % leff == 0) rst_q.push_back(cyc + ACC_LAT);
                if (beats % leff == leff - 1) out_q.push_back(cyc + LAT_OUT);
                beats++;
            end else begin
                bubbles++;
            end
            run_cyc++;
            @(posedge clk); #1;
            exp_wb = 0;
        end
        cfg_start = 1'b0; exp_req = 0; exp_beat = 0;
        while (done_cnt == 0 && wait_c < 200) begin
            data_vld = 1'($urandom);
            @(posedge clk); #1;
            exp_wb = 0;
            wait_c++;
        end
        check("done_seen", done_cnt, 1);
        if (done_cnt == 0) begin
            do_reset();
            return;
        end
        exp_busy = 0;
        idle(3);
        check("done_pulses", done_cnt, 1);
        check("out_valid_count", out_cnt, N);
        check("adder_rst_count", rst_cnt, N);
        check("pending_events", rst_q.size() + out_q.size(), 0);
`ifdef NPU_SCHED_PERF_EN
        check("perf_busy_cyc", perf_busy_cyc, done_cyc - s);
        check("perf_stall_cyc", perf_stall_cyc, bubbles);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        check("reset_adder_rst", adder_rst, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_done", done, 0);
        check("reset_gate", mac_data_gate, 1);
        @(posedge clk); #1;
        idle(2);
        // L, N, scale, bubble%, param delay, stall_after, stall_len, mid-run start, reset after beats
        run_job(4, 2, 5, 0, 1, -1, 0, 1'b0, -1);
        run_job(3, 2, 9, 0, 0, 2, 2, 1'b0, -1);
        run_job(0, 3, 3, 0, 2, -1, 0, 1'b0, -1);
        run_job(5, 0, 7, 0, 1, -1, 0, 1'b0, -1);
        run_job(4, 3, 6, 0, 0, -1, 0, 1'b0, 5);
        run_job(2, 2, 11, 0, 1, -1, 0, 1'b0, -1);
        run_job(3, 3, 12, 0, 0, 2, 7, 1'b1, -1);
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(5, 0)), int'($urandom_range(4, 0)), int'($urandom_range(15, 0)),
                    30, int'($urandom_range(3, 0)), -1, 0, 1'($urandom), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", fail);
        $fatal(1);
    end

endmodule
